// File: rtl/sw_debounce_pkg.sv
// Shared go-board definitions for switch debouncing: FSM encoding and timing defaults.
// Latency: n/a (types, constants and a width helper only).
// Backpressure: n/a.
package sw_debounce_pkg;

    // 10 ms of stability at the 25 MHz board clock.
    localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 250000;

    typedef enum logic [1:0] {
        IDLE_LO = 2'd0,
        CHK_HI  = 2'd1,
        IDLE_HI = 2'd2,
        CHK_LO  = 2'd3
    } sw_state_t;

    // Stability counter width: ceil(log2(cycles)), but never zero bits so that
    // DEBOUNCE_CYCLES=1 still gets a legal (constant-zero) counter.
    function automatic int unsigned stab_width(input int unsigned cycles);
        return (cycles <= 1) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer bringing an asynchronous board input into the clock domain.
// Latency: 2 clk cycles from d to q.
// Backpressure: none; free-running sampler.
//
// Ports:
//   clk   - sampling clock, rising edge
//   rst_n - asynchronous active-low reset, both flops clear to 0
//   d     - asynchronous input
//   q     - synchronized output (second flop)
module sync2 (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/sw_debounce.sv
// Debounces a bouncing board switch into a clean level plus press/release pulses and a press counter.
// Latency: 2 sync + 1 FSM entry + DEBOUNCE_CYCLES cycles from a clean SW edge to LEVEL/PRESS/RELEASE.
// Backpressure: none; PRESS/RELEASE are single-cycle pulses that are not held.
//
// Ports:
//   CLK     - system clock, rising edge
//   RST_N   - asynchronous active-low reset
//   SW      - raw asynchronous switch, 1 = pressed
//   LEVEL   - debounced switch level (registered)
//   PRESS   - one-cycle pulse on an accepted 0->1 transition
//   RELEASE - one-cycle pulse on an accepted 1->0 transition
//   COUNT   - accepted presses, modulo 2^CNT_W
module sw_debounce
    import sw_debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
    parameter int unsigned CNT_W           = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             SW,
    output logic             LEVEL,
    output logic             PRESS,
    output logic             RELEASE,
    output logic [CNT_W-1:0] COUNT
);

    localparam int unsigned      STAB_W   = stab_width(DEBOUNCE_CYCLES);
    localparam logic [STAB_W-1:0] STAB_MAX = STAB_W'(DEBOUNCE_CYCLES - 1);

    logic             sw_s;
    sw_state_t        state_q;
    sw_state_t        state_d;
    logic [STAB_W-1:0] stab_q;
    logic [STAB_W-1:0] stab_d;
    logic             level_d;
    logic             press_d;
    logic             release_d;
    logic [CNT_W-1:0] count_d;

    sync2 u_sync (
        .clk   (CLK),
        .rst_n (RST_N),
        .d     (SW),
        .q     (sw_s)
    );

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE_LO;
            stab_q  <= '0;
            LEVEL   <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
            COUNT   <= '0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            LEVEL   <= level_d;
            PRESS   <= press_d;
            RELEASE <= release_d;
            COUNT   <= count_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        stab_d    = stab_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        count_d   = COUNT;

        unique case (state_q)
            IDLE_LO: begin
                stab_d = '0;
                if (sw_s) begin
                    state_d = CHK_HI;
                end
            end
            CHK_HI: begin
                if (!sw_s) begin
                    // Bounce: abandon the check silently.
                    state_d = IDLE_LO;
                    stab_d  = '0;
                end else if (stab_q == STAB_MAX) begin
                    state_d = IDLE_HI;
                    stab_d  = '0;
                    press_d = 1'b1;
                    count_d = COUNT + CNT_W'(1);
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            IDLE_HI: begin
                stab_d = '0;
                if (!sw_s) begin
                    state_d = CHK_LO;
                end
            end
            CHK_LO: begin
                if (sw_s) begin
                    state_d = IDLE_HI;
                    stab_d  = '0;
                end else if (stab_q == STAB_MAX) begin
                    state_d   = IDLE_LO;
                    stab_d    = '0;
                    release_d = 1'b1;
                end else begin
                    stab_d = stab_q + STAB_W'(1);
                end
            end
            default: begin
                state_d = IDLE_LO;
                stab_d  = '0;
            end
        endcase

        // LEVEL follows the state being entered so it flips on the acceptance edge.
        level_d = (state_d == IDLE_HI) || (state_d == CHK_LO);
    end

endmodule

// File: tb/tb_sw_debounce.sv
// Directed bench for sw_debounce with DEBOUNCE_CYCLES=4, CNT_W=3.
// Latency: expected SW->LEVEL delay is 7 cycles for a clean edge.
// Backpressure: n/a.
module tb_sw_debounce;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       SW = 1'b0;
    logic       LEVEL;
    logic       PRESS;
    logic       RELEASE;
    logic [2:0] COUNT;

    int errors = 0;
    int checks = 0;

    sw_debounce #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .CLK     (CLK),
        .RST_N   (RST_N),
        .SW      (SW),
        .LEVEL   (LEVEL),
        .PRESS   (PRESS),
        .RELEASE (RELEASE),
        .COUNT   (COUNT)
    );

    always #5 CLK = ~CLK;

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RST_N = 1'b0;
        SW    = 1'b0;
        tick();
        tick();
        RST_N = 1'b1;
    endtask

    task automatic test_reset();
        RST_N = 1'b0;
        SW    = 1'b0;
        tick();
        tick();
        checks++; if (LEVEL !== 1'b0) begin errors++; $display("FAIL reset_level got %b want 0", LEVEL); end
        checks++; if (PRESS !== 1'b0) begin errors++; $display("FAIL reset_press got %b want 0", PRESS); end
        checks++; if (RELEASE !== 1'b0) begin errors++; $display("FAIL reset_release got %b want 0", RELEASE); end
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL reset_count got %0d want 0", COUNT); end
        RST_N = 1'b1;
        tick();
    endtask

    task automatic test_clean_press();
        logic [2:0] exp_cnt;
        SW = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_cnt = (k >= 7) ? 3'd1 : 3'd0;
            checks++; if (LEVEL !== (k >= 7)) begin errors++; $display("FAIL clean_press_level cyc %0d got %b want %b", k, LEVEL, (k >= 7)); end
            checks++; if (PRESS !== (k == 7)) begin errors++; $display("FAIL clean_press_pulse cyc %0d got %b want %b", k, PRESS, (k == 7)); end
            checks++; if (RELEASE !== 1'b0) begin errors++; $display("FAIL clean_press_release cyc %0d got %b want 0", k, RELEASE); end
            checks++; if (COUNT !== exp_cnt) begin errors++; $display("FAIL clean_press_count cyc %0d got %0d want %0d", k, COUNT, exp_cnt); end
        end
    endtask

    task automatic test_release();
        SW = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            checks++; if (LEVEL !== (k < 7)) begin errors++; $display("FAIL release_level cyc %0d got %b want %b", k, LEVEL, (k < 7)); end
            checks++; if (RELEASE !== (k == 7)) begin errors++; $display("FAIL release_pulse cyc %0d got %b want %b", k, RELEASE, (k == 7)); end
            checks++; if (PRESS !== 1'b0) begin errors++; $display("FAIL release_press cyc %0d got %b want 0", k, PRESS); end
            checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL release_count cyc %0d got %0d want 1", k, COUNT); end
        end
    endtask

    task automatic test_bounce();
        logic [2:0] exp_cnt;
        // 1,1,0,0,1,1,0,0 then hold 1: final edge lands after the 8th clock.
        for (int i = 0; i < 8; i++) begin
            SW = (((i >> 1) & 1) == 0);
            tick();
            checks++; if (LEVEL !== 1'b0) begin errors++; $display("FAIL bounce_level_early cyc %0d got %b want 0", i, LEVEL); end
            checks++; if (PRESS !== 1'b0) begin errors++; $display("FAIL bounce_press_early cyc %0d got %b want 0", i, PRESS); end
        end
        SW = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            exp_cnt = (k >= 7) ? 3'd2 : 3'd1;
            checks++; if (LEVEL !== (k >= 7)) begin errors++; $display("FAIL bounce_level cyc %0d got %b want %b", k, LEVEL, (k >= 7)); end
            checks++; if (PRESS !== (k == 7)) begin errors++; $display("FAIL bounce_press cyc %0d got %b want %b", k, PRESS, (k == 7)); end
            checks++; if (COUNT !== exp_cnt) begin errors++; $display("FAIL bounce_count cyc %0d got %0d want %0d", k, COUNT, exp_cnt); end
        end
        SW = 1'b0;
        for (int k = 0; k < 12; k++) tick();
        checks++; if (LEVEL !== 1'b0) begin errors++; $display("FAIL bounce_back_low got %b want 0", LEVEL); end
    endtask

    task automatic test_glitch();
        SW = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        SW = 1'b0;
        for (int k = 1; k <= 15; k++) begin
            tick();
            checks++; if (LEVEL !== 1'b0) begin errors++; $display("FAIL glitch_level cyc %0d got %b want 0", k, LEVEL); end
            checks++; if (PRESS !== 1'b0) begin errors++; $display("FAIL glitch_press cyc %0d got %b want 0", k, PRESS); end
            checks++; if (RELEASE !== 1'b0) begin errors++; $display("FAIL glitch_release cyc %0d got %b want 0", k, RELEASE); end
            checks++; if (COUNT !== 3'd2) begin errors++; $display("FAIL glitch_count cyc %0d got %0d want 2", k, COUNT); end
        end
    endtask

    task automatic test_wrap();
        logic [2:0] exp_cnt;
        do_reset();
        exp_cnt = 3'd0;
        for (int p = 1; p <= 8; p++) begin
            exp_cnt = exp_cnt + 3'd1;
            SW = 1'b1;
            for (int k = 0; k < 10; k++) tick();
            checks++; if (LEVEL !== 1'b1) begin errors++; $display("FAIL wrap_level_hi press %0d got %b want 1", p, LEVEL); end
            checks++; if (COUNT !== exp_cnt) begin errors++; $display("FAIL wrap_count press %0d got %0d want %0d", p, COUNT, exp_cnt); end
            SW = 1'b0;
            for (int k = 0; k < 10; k++) tick();
            checks++; if (LEVEL !== 1'b0) begin errors++; $display("FAIL wrap_level_lo press %0d got %b want 0", p, LEVEL); end
        end
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL wrap_final got %0d want 0", COUNT); end
    endtask

    task automatic test_mid_check_reset();
        logic [2:0] exp_cnt;
        do_reset();
        SW = 1'b1;
        for (int k = 0; k < 10; k++) tick();
        SW = 1'b0;
        for (int k = 0; k < 10; k++) tick();
        checks++; if (COUNT !== 3'd1) begin errors++; $display("FAIL midrst_pre_count got %0d want 1", COUNT); end
        SW = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        // Between edges: the reset must act without waiting for a clock.
        #2;
        RST_N = 1'b0;
        #1;
        checks++; if (LEVEL !== 1'b0) begin errors++; $display("FAIL midrst_level got %b want 0", LEVEL); end
        checks++; if (PRESS !== 1'b0) begin errors++; $display("FAIL midrst_press got %b want 0", PRESS); end
        checks++; if (RELEASE !== 1'b0) begin errors++; $display("FAIL midrst_release got %b want 0", RELEASE); end
        checks++; if (COUNT !== 3'd0) begin errors++; $display("FAIL midrst_count got %0d want 0", COUNT); end
        tick();
        tick();
        RST_N = 1'b1;
        for (int k = 1; k <= 15; k++) begin
            tick();
            exp_cnt = (k >= 7) ? 3'd1 : 3'd0;
            checks++; if (LEVEL !== (k >= 7)) begin errors++; $display("FAIL midrst_rel_level cyc %0d got %b want %b", k, LEVEL, (k >= 7)); end
            checks++; if (PRESS !== (k == 7)) begin errors++; $display("FAIL midrst_rel_press cyc %0d got %b want %b", k, PRESS, (k == 7)); end
            checks++; if (COUNT !== exp_cnt) begin errors++; $display("FAIL midrst_rel_count cyc %0d got %0d want %0d", k, COUNT, exp_cnt); end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_release();
        test_bounce();
        test_glitch();
        test_wrap();
        test_mid_check_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
